// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus: ID-stage issue info, WB activity and scoreboard outputs.
// Latency: n/a (signal bundle only).
// Backpressure: hazard is the stall request returned to the issuing pipeline.
interface hazard_scoreboard_if #(
  parameter int CNT_W = 16
);
  // ID-stage instruction under inspection
  logic             issue_valid;
  logic [3:0]       src1;
  logic [3:0]       src2;
  logic             two_src;
  logic             issue_wb_en;
  logic [3:0]       issue_dest;
  logic             issue_mem_read;
  // pipeline control
  logic             flush;
  logic             fwd_en;
  // write-back stage activity
  logic             write_back;
  logic [3:0]       dest_wb;
  // scoreboard results
  logic             hazard;
  logic [CNT_W-1:0] stall_cnt;
  logic             sb_err;

  // pipeline side: drives instruction/WB info, observes results
  modport master (
    output issue_valid, src1, src2, two_src, issue_wb_en, issue_dest,
           issue_mem_read, flush, fwd_en, write_back, dest_wb,
    input  hazard, stall_cnt, sb_err
  );

  // scoreboard side
  modport slave (
    input  issue_valid, src1, src2, two_src, issue_wb_en, issue_dest,
           issue_mem_read, flush, fwd_en, write_back, dest_wb,
    output hazard, stall_cnt, sb_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes in EX/MEM/WB and flags RAW hazards for the ID instruction.
// Latency: hazard is combinational (0 cycles); stall_cnt and sb_err update on the next edge.
// Backpressure: hazard=1 stalls IF/ID and forces a bubble into EX; the block itself never stalls.
module hazard_scoreboard #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  bus
);

  // One tracking slot per downstream stage.
  typedef struct packed {
    logic       vld;
    logic [3:0] dest;
    logic       load;
  } entry_t;

  localparam entry_t BUBBLE = '{vld: 1'b0, dest: 4'd0, load: 1'b0};

  entry_t           r_e0;   // instruction now in EX
  entry_t           r_e1;   // instruction now in MEM
  entry_t           r_e2;   // instruction now in WB
  entry_t           w_e0_nxt;

  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_sb_err;

  // per-stage source matches
  logic             w_e0_s1, w_e1_s1, w_e2_s1;
  logic             w_e0_s2, w_e1_s2, w_e2_s2;
  logic             w_any_s1, w_any_s2;
  logic             w_e0_hit;
  logic             w_hz_nofwd, w_hz_fwd;
  logic             w_hazard;
  logic             w_admit;
  logic             w_cnt_full;
  logic             w_wb_unexpected;
  logic             w_wb_missing;
  logic             w_wb_err;

  // Register valid & equal destination; R15 is an ordinary register here.
  function automatic logic match(input entry_t e, input logic [3:0] r);
    return e.vld && (e.dest == r);
  endfunction

  // Compare both ID sources against every tracked stage.
  always_comb begin
    w_e0_s1  = match(r_e0, bus.src1);
    w_e1_s1  = match(r_e1, bus.src1);
    w_e2_s1  = match(r_e2, bus.src1);
    w_e0_s2  = match(r_e0, bus.src2) && bus.two_src;
    w_e1_s2  = match(r_e1, bus.src2) && bus.two_src;
    w_e2_s2  = match(r_e2, bus.src2) && bus.two_src;
    w_any_s1 = w_e0_s1 || w_e1_s1 || w_e2_s1;
    w_any_s2 = w_e0_s2 || w_e1_s2 || w_e2_s2;
    w_e0_hit = w_e0_s1 || w_e0_s2;
  end

  // Without forwarding any pending writer stalls; with forwarding only a load
  // still in EX does, because its data is not available until after MEM.
  always_comb begin
    w_hz_nofwd = w_any_s1 || w_any_s2;
    w_hz_fwd   = r_e0.load && w_e0_hit;
    w_hazard   = bus.issue_valid && (bus.fwd_en ? w_hz_fwd : w_hz_nofwd);
  end

  // A writer enters EX only if it is real, not stalled and not squashed;
  // everything else (including stall/flush cycles) becomes a bubble.
  always_comb begin
    w_admit  = bus.issue_valid && bus.issue_wb_en && !w_hazard && !bus.flush;
    w_e0_nxt = BUBBLE;
    if (w_admit) begin
      w_e0_nxt.vld  = 1'b1;
      w_e0_nxt.dest = bus.issue_dest;
      w_e0_nxt.load = bus.issue_mem_read;
    end
  end

  // WB must write exactly when the WB slot holds a writer, and to its register.
  always_comb begin
    w_wb_unexpected = bus.write_back && (!r_e2.vld || (r_e2.dest != bus.dest_wb));
    w_wb_missing    = !bus.write_back && r_e2.vld;
    w_wb_err        = w_wb_unexpected || w_wb_missing;
    w_cnt_full      = &r_stall_cnt;
  end

  // Advance the tracking pipeline one stage per cycle; reset drops all in-flight writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_e0 <= BUBBLE;
      r_e1 <= BUBBLE;
      r_e2 <= BUBBLE;
    end else begin
      r_e2 <= r_e1;
      r_e1 <= r_e0;
      r_e0 <= w_e0_nxt;
    end
  end

  // Count stall cycles, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && !w_cnt_full) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Sticky consistency error between WB activity and the tracked pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sb_err <= 1'b0;
    end else if (w_wb_err) begin
      r_sb_err <= 1'b1;
    end
  end

  assign bus.hazard    = w_hazard;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.sb_err    = r_sb_err;

endmodule
